// File: rtl/mips_arith_pkg.sv
// Shared arithmetic definitions for the MIPS HI/LO datapath blocks.
// Holds the divider FSM encoding and the iteration-counter sizing rule.
package mips_arith_pkg;

   typedef logic [1:0] state_t;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CALC = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   // One extra bit so the counter can hold WIDTH itself without wrapping.
   function automatic int cnt_width(input int w);
      return $clog2(w) + 1;
   endfunction

endpackage

// File: rtl/div_restore_step.sv
// One restoring-division step on magnitudes.
// The partial remainder is shifted, fed the next dividend bit, and trial-subtracted.
module div_restore_step #(
   parameter int WIDTH = 16
) (
   input  logic [WIDTH:0] rem,
   input  logic           dividend_bit,
   input  logic [WIDTH:0] divisor,
   output logic [WIDTH:0] next_rem,
   output logic           q_bit
);

   logic [WIDTH+1:0] w_shift;
   logic [WIDTH+1:0] w_diff;

   assign w_shift  = {rem, dividend_bit};
   assign w_diff   = w_shift - {1'b0, divisor};

   // A clear top bit means the trial subtraction did not borrow.
   assign q_bit    = ~w_diff[WIDTH+1];
   assign next_rem = q_bit ? w_diff[WIDTH:0] : w_shift[WIDTH:0];

endmodule

// File: rtl/signed_divider_seq.sv
// Sequential signed divider: one quotient bit per clock on operand magnitudes,
// with sign fixup applied as the final result is registered.
module signed_divider_seq
   import mips_arith_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    start,
   input  logic signed [WIDTH-1:0] A,
   input  logic signed [WIDTH-1:0] B,
   output logic signed [WIDTH-1:0] Quotient,
   output logic signed [WIDTH-1:0] Remainder,
   output logic                    busy,
   output logic                    done,
   output logic                    div_by_zero
);

   localparam int              CNT_W     = cnt_width(WIDTH);
   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);
   localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);

   // Magnitude as an unsigned value; the most negative input maps to 2^(WIDTH-1).
   function automatic logic [WIDTH-1:0] mag(input logic signed [WIDTH-1:0] x);
      return x[WIDTH-1] ? ((~x) + ONE) : x;
   endfunction

   function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] x,
                                                   input logic            neg);
      return neg ? ((~x) + ONE) : x;
   endfunction

   logic [1:0]              r_state;
   logic [CNT_W-1:0]        r_iter;
   logic [WIDTH:0]          r_rem;
   logic [WIDTH-1:0]        r_dvd;
   logic [WIDTH-1:0]        r_dvs;
   logic [WIDTH-2:0]        r_quo;
   logic                    r_neg_q;
   logic                    r_neg_r;
   logic signed [WIDTH-1:0] r_q_out;
   logic signed [WIDTH-1:0] r_r_out;
   logic                    r_done;
   logic                    r_dbz;

   logic                    w_accept;
   logic                    w_b_zero;
   logic [WIDTH:0]          w_next_rem;
   logic                    w_q_bit;
   logic [WIDTH-1:0]        w_quo_final;
   logic [WIDTH-1:0]        w_q_fix;
   logic [WIDTH-1:0]        w_r_fix;

   assign w_accept    = start && ((r_state == S_IDLE) || (r_state == S_DONE));
   assign w_b_zero    = (B == '0);
   assign w_quo_final = {r_quo, w_q_bit};
   assign w_q_fix     = apply_sign(w_quo_final, r_neg_q);
   assign w_r_fix     = apply_sign(w_next_rem[WIDTH-1:0], r_neg_r);

   div_restore_step #(
      .WIDTH (WIDTH)
   ) u_step (
      .rem          (r_rem),
      .dividend_bit (r_dvd[WIDTH-1]),
      .divisor      ({1'b0, r_dvs}),
      .next_rem     (w_next_rem),
      .q_bit        (w_q_bit)
   );

   // Operand/partial-remainder datapath; meaningless outside CALC, so not reset.
   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_rem   <= '0;
         r_dvd   <= mag(A);
         r_dvs   <= mag(B);
         r_quo   <= '0;
         r_neg_q <= A[WIDTH-1] ^ B[WIDTH-1];
         r_neg_r <= A[WIDTH-1];
      end else if (r_state == S_CALC) begin
         r_rem   <= w_next_rem;
         r_dvd   <= {r_dvd[WIDTH-2:0], 1'b0};
         r_quo   <= {r_quo[WIDTH-3:0], w_q_bit};
      end
   end

   // Control and registered results.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_iter  <= '0;
         r_q_out <= '0;
         r_r_out <= '0;
         r_done  <= 1'b0;
         r_dbz   <= 1'b0;
      end else begin
         // done trails the DONE state by one cycle.
         r_done <= (r_state == S_DONE);
         case (r_state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  if (w_b_zero) begin
                     r_q_out <= '1;
                     r_r_out <= A;
                     r_dbz   <= 1'b1;
                     r_state <= S_DONE;
                  end else begin
                     r_dbz   <= 1'b0;
                     r_iter  <= '0;
                     r_state <= S_CALC;
                  end
               end else begin
                  r_state <= S_IDLE;
               end
            end
            S_CALC: begin
               if (r_iter == LAST_ITER) begin
                  r_q_out <= w_q_fix;
                  r_r_out <= w_r_fix;
                  r_state <= S_DONE;
               end else begin
                  r_iter <= r_iter + CNT_W'(1);
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign Quotient    = r_q_out;
   assign Remainder   = r_r_out;
   assign busy        = (r_state == S_CALC);
   assign done        = r_done;
   assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_signed_divider_seq.sv
// Bench for signed_divider_seq: vector table plus hand-written multi-cycle sequences,
// with a scoreboard queue popped on every done pulse.
module tb_signed_divider_seq;

   localparam int W = 16;

   logic         clk = 1'b0;
   logic         reset;
   logic         start;
   logic [W-1:0] A;
   logic [W-1:0] B;
   logic [W-1:0] Quotient;
   logic [W-1:0] Remainder;
   logic         busy;
   logic         done;
   logic         div_by_zero;

   typedef struct {
      logic [W-1:0] q;
      logic [W-1:0] r;
      logic         dz;
   } exp_t;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] q;
      logic [W-1:0] r;
      logic         dz;
   } vec_t;

   exp_t scb[$];
   int   checks   = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   signed_divider_seq #(
      .WIDTH (W)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .A           (A),
      .B           (B),
      .Quotient    (Quotient),
      .Remainder   (Remainder),
      .busy        (busy),
      .done        (done),
      .div_by_zero (div_by_zero)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
      exp_t e;
      logic signed [W-1:0] sa;
      logic signed [W-1:0] sd;
      sa = a;
      sd = b;
      if (b == '0) begin
         e.q = '1; e.r = a; e.dz = 1'b1;
      end else if (a == 16'h8000 && b == 16'hFFFF) begin
         e.q = 16'h8000; e.r = '0; e.dz = 1'b0;
      end else begin
         e.q = sa / sd; e.r = sa % sd; e.dz = 1'b0;
      end
      return e;
   endfunction

   // Scoreboard: every done pulse consumes the oldest expected result.
   always @(negedge clk) begin
      exp_t e;
      if (done === 1'b1) begin
         if (scb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_done actual=1 required=0");
         end else begin
            e = scb.pop_front();
            check("quotient", Quotient, e.q);
            check("remainder", Remainder, e.r);
            check("div_by_zero", div_by_zero, e.dz);
         end
      end
   end

   // Called at the negedge right after the accepting edge; skips a done already
   // showing there and waits for the next one.
   task automatic wait_done(input string tag, input int exp_lat, input int exp_busy);
      int n = 0;
      int nb = 0;
      bit seen = 1'b0;
      if (busy) nb++;
      while (n < 60) begin
         @(negedge clk);
         n++;
         if (done) begin
            seen = 1'b1;
            break;
         end
         if (busy) nb++;
      end
      check({tag, "_latency"}, seen ? n : -1, exp_lat);
      check({tag, "_busy_cycles"}, nb, exp_busy);
   endtask

   task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input exp_t e);
      A = a; B = b; start = 1'b1;
      scb.push_back(e);
      @(negedge clk);
      start = 1'b0;
      wait_done(tag, e.dz ? 1 : W + 1, e.dz ? 0 : W);
   endtask

   vec_t tbl[16];

   initial begin
      exp_t e;
      int   g;
      int   nb;
      logic [W-1:0] ra;
      logic [W-1:0] rb;

      tbl[0]  = '{16'h0064, 16'h0007, 16'h000E, 16'h0002, 1'b0};
      tbl[1]  = '{16'hFF9C, 16'h0007, 16'hFFF2, 16'hFFFE, 1'b0};
      tbl[2]  = '{16'h0064, 16'hFFF9, 16'hFFF2, 16'h0002, 1'b0};
      tbl[3]  = '{16'hFF9C, 16'hFFF9, 16'h000E, 16'hFFFE, 1'b0};
      tbl[4]  = '{16'h8000, 16'hFFFF, 16'h8000, 16'h0000, 1'b0};
      tbl[5]  = '{16'h0005, 16'h0000, 16'hFFFF, 16'h0005, 1'b1};
      tbl[6]  = '{16'h8000, 16'h0001, 16'h8000, 16'h0000, 1'b0};
      tbl[7]  = '{16'h8000, 16'h8000, 16'h0001, 16'h0000, 1'b0};
      tbl[8]  = '{16'h7FFF, 16'h8000, 16'h0000, 16'h7FFF, 1'b0};
      tbl[9]  = '{16'h8000, 16'h0003, 16'hD556, 16'hFFFE, 1'b0};
      tbl[10] = '{16'h0000, 16'h0005, 16'h0000, 16'h0000, 1'b0};
      tbl[11] = '{16'h7FFF, 16'h0001, 16'h7FFF, 16'h0000, 1'b0};
      tbl[12] = '{16'hFFFF, 16'h0000, 16'hFFFF, 16'hFFFF, 1'b1};
      tbl[13] = '{16'h0003, 16'h0007, 16'h0000, 16'h0003, 1'b0};
      tbl[14] = '{16'hFFFD, 16'h0007, 16'h0000, 16'hFFFD, 1'b0};
      tbl[15] = '{16'h8000, 16'h0002, 16'hC000, 16'h0000, 1'b0};

      reset = 1'b1; start = 1'b0; A = '0; B = '0;
      repeat (3) @(negedge clk);
      check("rst_quotient", Quotient, 0);
      check("rst_remainder", Remainder, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_dbz", div_by_zero, 0);
      reset = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 16; i++) begin
         e.q = tbl[i].q; e.r = tbl[i].r; e.dz = tbl[i].dz;
         run_op($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, e);
         @(negedge clk);
      end

      for (int i = 0; i < 6; i++) begin
         ra = 16'($urandom);
         rb = 16'($urandom_range(1, 300));
         if (i[0]) rb = ~rb + 16'd1;
         run_op($sformatf("rnd%0d", i), ra, rb, model(ra, rb));
      end

      // div_by_zero holds after done, then clears on the next accepted start.
      run_op("dz_hold", 16'h0005, 16'h0000, model(16'h0005, 16'h0000));
      repeat (3) @(negedge clk);
      check("dz_held", div_by_zero, 1);
      run_op("dz_clear", 16'h0064, 16'h0007, model(16'h0064, 16'h0007));

      // Start while busy is ignored; start from DONE is accepted.
      @(negedge clk);
      A = 16'd100; B = 16'd7; start = 1'b1;
      scb.push_back(model(16'd100, 16'd7));
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      check("busy_mid_calc", busy, 1);
      A = 16'd9; B = 16'd3; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      g = 0;
      while (busy && g < 40) begin
         @(negedge clk);
         g++;
      end
      check("calc_end_seen", busy, 0);
      A = 16'd9; B = 16'd3; start = 1'b1;
      scb.push_back(model(16'd9, 16'd3));
      @(negedge clk);
      start = 1'b0;
      check("accept_from_done", busy, 1);
      wait_done("from_done", W + 1, W);

      // Reset in the middle of CALC discards the operation.
      @(negedge clk);
      A = 16'd100; B = 16'd7; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (7) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("midrst_quotient", Quotient, 0);
      check("midrst_remainder", Remainder, 0);
      check("midrst_busy", busy, 0);
      check("midrst_done", done, 0);
      check("midrst_dbz", div_by_zero, 0);
      reset = 1'b0;
      nb = 0;
      repeat (20) begin
         @(negedge clk);
         if (busy) nb++;
      end
      check("midrst_idle", nb, 0);
      run_op("after_rst", 16'd100, 16'd7, model(16'd100, 16'd7));

      repeat (3) @(negedge clk);
      check("scoreboard_empty", scb.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
